// File: rtl/jtag_tap_master.sv
// jtag_tap_master: on-chip JTAG initiator. Accepts TAP-reset / IR-scan /
// DR-scan / idle commands, generates TCK/TMS/TDI at clk/CLK_DIV, captures
// TDO during shift periods and always leaves the TAP in Run-Test/Idle.
// If the TAP state is unknown, a scan or idle command first walks the TAP
// through Test-Logic-Reset so the TMS paths below are valid.
module jtag_tap_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 38,
    parameter int LEN_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);

    localparam int HALF = CLK_DIV / 2;
    localparam int PH_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    // Phase counter values: last clk of a period, first high clk, and the
    // clk whose closing edge raises tck (where tdo is sampled).
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(HALF);
    localparam logic [PH_W-1:0] PH_SAMP = PH_W'(HALF - 1);

    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] SYNC_LAST = LEN_W'(5);

    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_IR    = 2'b01;
    localparam logic [1:0] CMD_DR    = 2'b10;
    localparam logic [1:0] CMD_IDLE  = 2'b11;

    // SYNC: Test-Logic-Reset walk, PRE: RTI -> Shift-xR, SHIFT: data bits,
    // POST: Exit1 -> Update -> RTI, RESP: holding the response.
    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PRE,
        SHIFT,
        POST,
        RESP
    } state_t;

    state_t            state, state_n;
    logic [PH_W-1:0]   phase, phase_n;
    logic [LEN_W-1:0]  step, step_n;
    logic              tap_synced, tap_synced_n;

    logic [1:0]        type_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] data_q;

    logic              accept;
    logic [LEN_W-1:0]  clamped_len;
    logic [1:0]        cur_type;
    logic [LEN_W-1:0]  cur_len;
    logic [DATA_W-1:0] cur_data;
    logic [LEN_W-1:0]  pre_last;
    logic              period_end;
    logic              active_n;

    logic              tck_n, tms_n, tdi_n;
    logic              busy_n, rsp_valid_n, cmd_ready_n;

    // The command fields seen by the FSM: live inputs on the accept cycle so
    // the first TMS bit can be registered on that very edge, latched copies after.
    always_comb begin
        accept      = cmd_valid && cmd_ready;
        clamped_len = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
        cur_type    = accept ? cmd_type : type_q;
        cur_len     = accept ? clamped_len : len_q;
        cur_data    = accept ? cmd_data : data_q;
        pre_last    = (cur_type == CMD_DR) ? LEN_W'(2) : LEN_W'(3);
        period_end  = (phase == PH_LAST);
    end

    // State register: FSM state, position inside the TCK period, period index
    // inside the current TMS segment, and whether the TAP state is known.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            step       <= '0;
            tap_synced <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            step       <= step_n;
            tap_synced <= tap_synced_n;
        end
    end

    // Next-state logic: segments advance only at the end of a full TCK period.
    always_comb begin
        state_n      = state;
        phase_n      = phase;
        step_n       = step;
        tap_synced_n = tap_synced;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    phase_n = '0;
                    step_n  = '0;
                    if (cmd_type == CMD_RESET || !tap_synced) begin
                        state_n = SYNC;
                    end else if (clamped_len == '0) begin
                        state_n = RESP;
                    end else if (cmd_type == CMD_IDLE) begin
                        state_n = SHIFT;
                    end else begin
                        state_n = PRE;
                    end
                end
            end
            SYNC, PRE, SHIFT, POST: begin
                if (!period_end) begin
                    phase_n = phase + 1'b1;
                end else begin
                    phase_n = '0;
                    step_n  = step + 1'b1;
                    case (state)
                        SYNC: begin
                            if (step == SYNC_LAST) begin
                                step_n       = '0;
                                tap_synced_n = 1'b1;
                                if (cur_type == CMD_RESET || cur_len == '0) begin
                                    state_n = RESP;
                                end else if (cur_type == CMD_IDLE) begin
                                    state_n = SHIFT;
                                end else begin
                                    state_n = PRE;
                                end
                            end
                        end
                        PRE: begin
                            if (step == pre_last) begin
                                step_n  = '0;
                                state_n = SHIFT;
                            end
                        end
                        SHIFT: begin
                            if (step == cur_len - 1'b1) begin
                                step_n  = '0;
                                state_n = (cur_type == CMD_IDLE) ? RESP : POST;
                            end
                        end
                        POST: begin
                            if (step == LEN_W'(1)) begin
                                step_n  = '0;
                                state_n = RESP;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output decode from the next state, so every pin comes straight from a
    // flop; TMS/TDI only move when a new period (low phase) begins.
    always_comb begin
        active_n    = (state_n == SYNC) || (state_n == PRE) ||
                      (state_n == SHIFT) || (state_n == POST);
        tck_n       = 1'b0;
        tms_n       = tms;
        tdi_n       = tdi;
        busy_n      = active_n;
        rsp_valid_n = (state_n == RESP);
        cmd_ready_n = (state_n == IDLE);
        if (active_n) begin
            tck_n = (phase_n >= PH_RISE);
            if (phase_n == '0) begin
                tdi_n = 1'b0;
                case (state_n)
                    SYNC: begin
                        tms_n = (step_n != SYNC_LAST);
                    end
                    PRE: begin
                        tms_n = (cur_type == CMD_DR) ? (step_n == '0)
                                                     : (step_n < LEN_W'(2));
                    end
                    SHIFT: begin
                        tms_n = (cur_type != CMD_IDLE) && (step_n == cur_len - 1'b1);
                        tdi_n = (cur_type != CMD_IDLE) && cur_data[step_n];
                    end
                    POST: begin
                        tms_n = (step_n == '0);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output registers for the JTAG pins and the handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            tck       <= tck_n;
            tms       <= tms_n;
            tdi       <= tdi_n;
            busy      <= busy_n;
            rsp_valid <= rsp_valid_n;
            cmd_ready <= cmd_ready_n;
        end
    end

    // Command latch and TDO capture; the capture buffer is cleared on accept
    // so unused high bits and non-scan commands report zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            type_q   <= CMD_RESET;
            len_q    <= '0;
            data_q   <= '0;
            rsp_data <= '0;
        end else if (accept) begin
            type_q   <= cmd_type;
            len_q    <= clamped_len;
            data_q   <= cmd_data;
            rsp_data <= '0;
        end else if (state == SHIFT && type_q != CMD_IDLE && phase == PH_SAMP) begin
            rsp_data[step] <= tdo;
        end
    end

endmodule

// File: tb/tb_jtag_tap_master.sv
// tb_jtag_tap_master: directed bench for jtag_tap_master. A command-level
// model predicts the TMS/TDI bit per TCK period, the response data and the
// latency; a monitor compares every TCK rising edge against that prediction.
module tb_jtag_tap_master;

    localparam int CLK_DIV = 4;
    localparam int DATA_W  = 38;
    localparam int LEN_W   = 6;
    localparam int HALF    = CLK_DIV / 2;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              rsp_ready = 1'b0;
    logic [1:0]        cmd_type  = 2'b00;
    logic [LEN_W-1:0]  cmd_len   = '0;
    logic [DATA_W-1:0] cmd_data  = '0;
    logic              cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
    logic [DATA_W-1:0] rsp_data;

    // 0 = tdo looped from tdi, 1 = tdo tied high, 2 = tdo tied low
    int tdo_mode = 0;
    assign tdo = (tdo_mode == 0) ? tdi : (tdo_mode == 1);

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    bit                model_synced = 1'b0;
    bit                exp_tms[$];
    bit                exp_tdi[$];
    logic [DATA_W-1:0] exp_rsp;
    int                exp_periods;

    // Observed traces of the current command (first period in the MSB side)
    logic [63:0] tms_trace = '0;
    logic [63:0] tdi_trace = '0;
    logic        prev_tck  = 1'b0;
    int          high_run  = 0;

    jtag_tap_master #(
        .CLK_DIV(CLK_DIV),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_type (cmd_type),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .busy     (busy),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tdo      (tdo)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic push_period(input bit m, input bit d);
        exp_tms.push_back(m);
        exp_tdi.push_back(d);
        exp_periods++;
    endtask

    // Predict the JTAG activity and response of one command
    task automatic model_cmd(input logic [1:0] t, input int len, input logic [DATA_W-1:0] d, input int mode);
        int l;
        l = (len > DATA_W) ? DATA_W : len;
        exp_periods = 0;
        exp_rsp     = '0;
        if (t == 2'b00 || !model_synced) begin
            for (int i = 0; i < 6; i++) push_period(i < 5, 1'b0);
            model_synced = 1'b1;
        end
        if (t != 2'b00 && l > 0) begin
            if (t == 2'b01) begin
                push_period(1'b1, 1'b0); push_period(1'b1, 1'b0);
                push_period(1'b0, 1'b0); push_period(1'b0, 1'b0);
            end else if (t == 2'b10) begin
                push_period(1'b1, 1'b0); push_period(1'b0, 1'b0); push_period(1'b0, 1'b0);
            end
            for (int i = 0; i < l; i++) begin
                if (t == 2'b11) begin
                    push_period(1'b0, 1'b0);
                end else begin
                    push_period(i == l - 1, d[i]);
                    exp_rsp[i] = (mode == 0) ? d[i] : (mode == 1);
                end
            end
            if (t != 2'b11) begin
                push_period(1'b1, 1'b0); push_period(1'b0, 1'b0);
            end
        end
    endtask

    // Check each TCK rise against the model and each high phase for width
    always @(negedge clk) begin
        bit em, ed;
        if (tck) begin
            high_run++;
        end else begin
            if (prev_tck) checkOutput("tck high width", 64'(high_run), 64'(HALF));
            high_run = 0;
        end
        if (tck && !prev_tck) begin
            tms_trace = {tms_trace[62:0], tms};
            tdi_trace = {tdi_trace[62:0], tdi};
            if (exp_tms.size() == 0) begin
                checkOutput("unexpected tck rise", 64'd1, 64'd0);
            end else begin
                em = exp_tms.pop_front();
                ed = exp_tdi.pop_front();
                checkOutput("tms at tck rise", {63'd0, tms}, {63'd0, em});
                checkOutput("tdi at tck rise", {63'd0, tdi}, {63'd0, ed});
            end
        end
        prev_tck = tck;
    end

    // Issue one command, wait for its response, check it, optionally hold it
    task automatic applyStimulus(input string name, input logic [1:0] t, input int len,
                                 input logic [DATA_W-1:0] d, input int mode, input int hold,
                                 output int lat);
        int w;
        int cycles;
        logic [DATA_W-1:0] held;
        lat = -1;
        w = 0;
        while (!cmd_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            checkOutput({name, " cmd_ready timeout"}, 64'd0, 64'd1);
            return;
        end
        tdo_mode = mode;
        model_cmd(t, len, d, mode);
        tms_trace = '0;
        tdi_trace = '0;
        cmd_type  = t;
        cmd_len   = LEN_W'(len);
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (exp_periods > 0) checkOutput({name, " busy"}, {63'd0, busy}, 64'd1);
        cycles = 1;
        while (!rsp_valid && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
        if (!rsp_valid) begin
            checkOutput({name, " rsp_valid timeout"}, 64'd0, 64'd1);
            return;
        end
        lat = cycles - 1;
        checkOutput({name, " latency"}, 64'(lat), 64'(exp_periods * CLK_DIV));
        checkOutput({name, " rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
        checkOutput({name, " missing periods"}, 64'(exp_tms.size()), 64'd0);
        checkOutput({name, " busy at rsp"}, {63'd0, busy}, 64'd0);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({name, " hold rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
            checkOutput({name, " hold rsp_data"}, 64'(rsp_data), 64'(held));
            checkOutput({name, " hold cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
            checkOutput({name, " hold tck"}, {63'd0, tck}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({name, " rsp_valid drop"}, {63'd0, rsp_valid}, 64'd0);
        checkOutput({name, " cmd_ready after consume"}, {63'd0, cmd_ready}, 64'd1);
    endtask

    // Backstop in case a bounded wait is missed
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation stuck");
    end

    // Directed sequence
    initial begin
        int lat;
        bit bad;

        repeat (3) @(negedge clk);
        checkOutput("reset tck", {63'd0, tck}, 64'd0);
        checkOutput("reset tms", {63'd0, tms}, 64'd1);
        checkOutput("reset tdi", {63'd0, tdi}, 64'd0);
        checkOutput("reset cmd_ready", {63'd0, cmd_ready}, 64'd0);
        checkOutput("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset rsp_data", 64'(rsp_data), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("cmd_ready after reset", {63'd0, cmd_ready}, 64'd1);

        // TAP reset: 6 periods, 24 clk
        applyStimulus("tap reset", 2'b00, 0, '0, 0, 0, lat);
        checkOutput("tap reset latency pin", 64'(lat), 64'd24);
        checkOutput("tap reset tms trace", tms_trace, 64'b111110);

        // Fresh reset, then a DR scan that must auto-sync first
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_synced = 1'b0;
        @(negedge clk);
        applyStimulus("dr8 autosync", 2'b10, 8, 38'hA5, 0, 0, lat);
        checkOutput("dr8 latency pin", 64'(lat), 64'd76);
        checkOutput("dr8 rsp pin", 64'(rsp_data), 64'hA5);
        checkOutput("dr8 tms trace", tms_trace, 64'b1111101000000000110);

        // Synced IR scan, tdo tied high
        applyStimulus("ir2", 2'b01, 2, 38'b10, 1, 0, lat);
        checkOutput("ir2 latency pin", 64'(lat), 64'd32);
        checkOutput("ir2 rsp pin", 64'(rsp_data), 64'h3);
        checkOutput("ir2 tms trace", tms_trace, 64'b11000110);
        checkOutput("ir2 tdi trace", tdi_trace, 64'b00000100);

        // Full-width DR with a held response, then a clamped length
        applyStimulus("dr38 hold", 2'b10, 38, 38'h2A_AAAA_AAAA, 0, 10, lat);
        checkOutput("dr38 rsp pin", 64'(rsp_data), 64'h2A_AAAA_AAAA);
        applyStimulus("dr50 clamp", 2'b10, 50, 38'h2A_AAAA_AAAA, 0, 0, lat);
        checkOutput("dr50 latency pin", 64'(lat), 64'd172);
        checkOutput("dr50 rsp pin", 64'(rsp_data), 64'h2A_AAAA_AAAA);

        // Idle cycles, zero-length scan, and a scan with tdo tied low
        applyStimulus("idle5", 2'b11, 5, 38'h1F, 0, 0, lat);
        checkOutput("idle5 latency pin", 64'(lat), 64'd20);
        checkOutput("idle5 tms trace", tms_trace, 64'd0);
        applyStimulus("dr0", 2'b10, 0, 38'hFF, 0, 0, lat);
        checkOutput("dr0 latency pin", 64'(lat), 64'd0);
        applyStimulus("ir3 tdo0", 2'b01, 3, 38'b101, 2, 0, lat);
        checkOutput("ir3 rsp pin", 64'(rsp_data), 64'd0);

        // Reset in the middle of a shift: no response, sync needed again
        tdo_mode = 0;
        model_cmd(2'b10, 20, 38'h0F0F1, 0);
        cmd_type  = 2'b10;
        cmd_len   = LEN_W'(20);
        cmd_data  = 38'h0F0F1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (29) @(negedge clk);
        checkOutput("midreset busy before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_tms.delete();
        exp_tdi.delete();
        model_synced = 1'b0;
        checkOutput("midreset tck", {63'd0, tck}, 64'd0);
        checkOutput("midreset tms", {63'd0, tms}, 64'd1);
        checkOutput("midreset tdi", {63'd0, tdi}, 64'd0);
        checkOutput("midreset busy", {63'd0, busy}, 64'd0);
        checkOutput("midreset rsp_data", 64'(rsp_data), 64'd0);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || tck) bad = 1'b1;
        end
        checkOutput("midreset quiet", {63'd0, bad}, 64'd0);
        applyStimulus("dr4 resync", 2'b10, 4, 38'b1001, 0, 0, lat);
        checkOutput("dr4 latency pin", 64'(lat), 64'd60);
        checkOutput("dr4 rsp pin", 64'(rsp_data), 64'h9);
        checkOutput("dr4 tms trace", tms_trace, 64'b111110100000110);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
